vector_mem_gather: RTL



---
 rtl/vector_mem_pkg.sv | 16 +
 rtl/vector_mem_gather_if.sv | 36 +++
 rtl/vector_mem_gather.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/vector_mem_pkg.sv
// rtl/vector_mem_pkg.sv - shared widths and FSM state type for the vector gather unit
package vector_mem_pkg;

  localparam int VEC_W  = 128;
  localparam int WORD_W = 32;
  localparam int BEATS  = VEC_W / WORD_W;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    DONE
  } vmg_state_t;

endpackage

// File: rtl/vector_mem_gather_if.sv
// rtl/vector_mem_gather_if.sv - word-wide data memory port; store signals only with VECTOR_MEM_STORE_EN
interface vector_mem_gather_if
  import vector_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [WORD_W-1:0] mem_rdata;
`ifdef VECTOR_MEM_STORE_EN
  logic              mem_we;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    output mem_req, mem_addr, mem_we, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );
  modport slave (
    input  mem_req, mem_addr, mem_we, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
`else
  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata
  );
  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata
  );
`endif

endinterface

// File: rtl/vector_mem_gather.sv
// rtl/vector_mem_gather.sv - gathers a 128-bit vector from four word loads; VECTOR_MEM_STORE_EN adds the scatter path
module vector_mem_gather
  import vector_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
`ifdef VECTOR_MEM_STORE_EN
  input  logic               req_we,
  input  logic [VEC_W-1:0]   req_wdata,
`endif
  vector_mem_gather_if.master mem,
  output logic               rsp_valid,
  output logic [VEC_W-1:0]   rsp_data,
  output logic               busy
);

  vmg_state_t        state_q, state_d;
  logic [1:0]        beat_q, beat_d, beat_nxt;
  logic [ADDR_W-1:0] base_q, base_d, next_addr;
  logic [VEC_W-1:0]  asm_q, asm_d;
  logic [VEC_W-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [6:0]        lane_lo;
  logic              accept;
  logic              is_store;

  assign req_ready = rst_n && (state_q == IDLE) && !flush;
  assign busy      = (state_q != IDLE);
  assign accept    = req_valid && req_ready;
  assign beat_nxt  = beat_q + 2'd1;
  assign next_addr = base_q + ADDR_W'({beat_nxt, 2'b00});
  assign lane_lo   = {beat_q, 5'b00000};

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    base_d      = base_q;
    asm_d       = asm_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          base_d     = req_addr & ~ADDR_W'(4'hF);
          beat_d     = 2'd0;
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = req_addr & ~ADDR_W'(4'hF);
        end
      end
      REQ: begin
        if (flush) begin
          // A granted load still owes us an rvalid, so it must be drained.
          mem_req_d = 1'b0;
          state_d   = (mem.mem_gnt && !is_store) ? DRAIN : IDLE;
        end else if (mem.mem_gnt) begin
          if (!is_store) begin
            state_d   = WAIT;
            mem_req_d = 1'b0;
          end else if (beat_q == 2'd3) begin
            state_d     = DONE;
            mem_req_d   = 1'b0;
            rsp_valid_d = 1'b1;
          end else begin
            beat_d     = beat_nxt;
            mem_addr_d = next_addr;
          end
        end
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            asm_d[lane_lo +: WORD_W] = mem.mem_rdata;
            if (beat_q == 2'd3) begin
              state_d     = DONE;
              rsp_valid_d = 1'b1;
              rsp_data_d  = asm_d;
            end else begin
              beat_d     = beat_nxt;
              state_d    = REQ;
              mem_req_d  = 1'b1;
              mem_addr_d = next_addr;
            end
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem.mem_rvalid) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      base_q      <= '0;
      asm_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      asm_q       <= asm_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;

`ifdef VECTOR_MEM_STORE_EN
  logic              is_store_q, is_store_d;
  logic [VEC_W-1:0]  wbuf_q, wbuf_d;
  logic              mem_we_q, mem_we_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;

  assign is_store = is_store_q;

  // Store strobe and data follow the registered request, lane chosen by the next beat.
  always_comb begin
    is_store_d = is_store_q;
    wbuf_d     = wbuf_q;
    if (accept) begin
      is_store_d = req_we;
      wbuf_d     = req_wdata;
    end
    mem_we_d    = mem_req_d && is_store_d;
    mem_wdata_d = '0;
    if (mem_we_d) begin
      mem_wdata_d = wbuf_d[{beat_d, 5'b00000} +: WORD_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q  <= 1'b0;
      wbuf_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      is_store_q  <= is_store_d;
      wbuf_q      <= wbuf_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem.mem_we    = mem_we_q;
  assign mem.mem_wdata = mem_wdata_q;
`else
  assign is_store = 1'b0;
`endif

endmodule
